mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the five-stage pipeline.
- Serialises their accesses with a fixed-latency memory handshake and drives per-stage stall signals so the pipeline registers hold while an access is outstanding.
- Priority goes to data accesses, which belong to the older instruction, with a bounded-starvation guarantee for fetch.
- Fetch responses can be squashed by a branch/jump flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (≥1), counted from the mem_en cycle to the cycle mem_rdata is valid
- MAX_D_STREAK, 4, maximum number of consecutive data grants issued while if_req is pending

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- stall_if  out  1  = if_req & ~if_ack
- flush  in  1  kill the in-flight or pending-response fetch
- dm_req  in  1  data request; held stable with dm_we/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, valid when dm_ack on a read
- dm_ack  out  1  one-cycle data completion pulse
- stall_dm  out  1  = dm_req & ~dm_ack
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate on sampled requests.
  - Grant fetch if if_req is high and either dm_req is low or streak == MAX_D_STREAK.
  - Otherwise grant data if dm_req is high.
  - On grant: latch owner, addr, we, wdata; go to ISSUE. With no request, stay in IDLE.
- ISSUE: mem_en=1 and mem_we/addr/wdata driven from the latched values for exactly one cycle. Down-counter loads MEM_LAT-1.
  - Go to RESP if MEM_LAT==1, otherwise go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
  - With MEM_LAT==1, the capture happens at the end of ISSUE.
- RESP: assert the owner's ack for one cycle, then go to IDLE.
  - No arbitration in RESP, so a still-high req in the ack cycle is never re-granted.
- Streak counter (saturating at MAX_D_STREAK):
  - increments on a data grant while if_req is high;
  - clears on a fetch grant;
  - clears on a data grant while if_req is low.
- Writes: dm_ack pulses; dm_rdata is unchanged.
- Flush: flush high in any cycle while the owner is fetch (ISSUE, WAIT or RESP) sets a kill flag.
  - A killed fetch completes its memory cycle, but if_ack stays 0 and if_rdata is unchanged.
  - The kill flag clears on entry to IDLE.
  - flush has no effect on data transactions or in IDLE.
- mem_* outputs are registered. When mem_en=0, mem_we=0 and addr/wdata hold their last values.

## Timing
- Request sampled in IDLE at cycle t:
  - mem_en in cycle t+1;
  - ack in cycle t+1+MEM_LAT;
  - next grant evaluated at t+2+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles. Per-access latency is MEM_LAT+1 cycles.
- if_ack and dm_ack are never high together. At most one mem_en per transaction.
- Reset values: state IDLE, streak 0, kill 0; all outputs 0, including if_rdata and dm_rdata.
- Reset asserted mid-transaction: state returns to IDLE immediately and mem_en drops asynchronously. No ack is issued for the abandoned access.
- stall_if and stall_dm are combinational from the req inputs and the registered acks.

## Test plan
- Reset then single fetch (MEM_LAT=2): if_req=1 at t with if_addr=0x10 and mem returning 0x2010_0004 → mem_en/addr=0x10 at t+1; if_ack=1 with if_rdata=0x2010_0004 at t+3; stall_if=1 during t..t+2.
- Simultaneous if_req and dm_req (read of 0x40): data is granted first (dm_ack at t+3), then fetch (if_ack at t+7). Acks are never coincident.
- Starvation bound: dm_req and if_req held continuously for 6 accesses → grants are D,D,D,D,F,D and the streak returns to 0 after F.
- Write: dm_we=1, addr=0x80, wdata=0xDEAD_BEEF → one mem_en cycle with mem_we=1 and those values; dm_ack at t+3; dm_rdata unchanged.
- Flush: flush pulses during WAIT of a fetch → no if_ack, if_rdata unchanged, FSM returns to IDLE at t+4. A refetch then completes normally.
- Async reset asserted in WAIT → mem_en=0 and acks=0 immediately. After release, a fresh request is serviced with nominal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins ties; a streak limit bounds how long fetch can be held off.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              stall_if,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | arbitrate sampled requests
  // ISSUE | mem_en strobe, counter loaded
  // WAIT  | counting down to read-data valid
  // RESP  | owner's ack pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] streak;
  logic             kill;
  logic             owner_dm;
  logic             lat_we;

  logic streak_max;
  logic grant_if;
  logic grant_dm;
  logic done;

  assign streak_max = (streak == STK_W'(MAX_D_STREAK));
  assign grant_if   = if_req && (!dm_req || streak_max);
  assign grant_dm   = dm_req && !grant_if;
  assign done       = ((state == ISSUE) && (MEM_LAT == 1)) ||
                      ((state == WAIT) && (cnt == CNT_W'(1)));

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      kill      <= 1'b0;
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_if) begin
            state    <= ISSUE;
            owner_dm <= 1'b0;
            lat_we   <= 1'b0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            streak   <= '0;
          end else if (grant_dm) begin
            state     <= ISSUE;
            owner_dm  <= 1'b1;
            lat_we    <= dm_we;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req)
              streak <= '0;
            else if (!streak_max)
              streak <= streak + STK_W'(1);
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= CNT_W'(MEM_LAT - 1);
          if (MEM_LAT > 1)
            state <= WAIT;
        end
        WAIT: cnt <= cnt - CNT_W'(1);
        RESP: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if ((state != IDLE) && !owner_dm && flush)
        kill <= 1'b1;

      // A flush in the capture cycle itself must also suppress the fetch response
      if (done) begin
        state <= RESP;
        if (owner_dm) begin
          dm_ack <= 1'b1;
          if (!lat_we)
            dm_rdata <= mem_rdata;
        end else if (!(kill || flush)) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
